gcl_exec_m: RTL and testbench

Downstream execution stage for the GC copy controller. It accepts one `gclop_t` command per cycle (NOP, WRA, RDA, CPAB), executes it against two internal semispace RAMs (from-space and to-space), and reports per-command responses. It also checks read data against `datachk` and keeps copy and error statistics. On request it swaps semispace roles between collection cycles, so the controller always reads "A" and writes "B".

---
 rtl/gcltypes_pkg.sv | 37 +++
 rtl/gcl_exec_m_sram.sv | 26 ++
 rtl/gcl_exec_m.sv | 195 +++++++++++++++++++
 tb/tb_gcl_exec_m.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gcltypes_pkg.sv
// Shared types for the GC copy controller and its execution stage:
// command encoding, command struct, and the execution-stage swap FSM states.
package gcltypes;

    localparam int A_size = 4;
    localparam int D_size = 8;
    localparam int ID_W   = 4;
    localparam int ADR_W  = 6;

    typedef enum logic [1:0] {
        NOP  = 2'd0,
        WRA  = 2'd1,
        RDA  = 2'd2,
        CPAB = 2'd3
    } gclcmd_t;

    // Address fields are wider than A_size; only the low A_size bits are used.
    typedef struct packed {
        logic [ID_W-1:0]   id;
        gclcmd_t           cmd;
        logic [ADR_W-1:0]  adr1;
        logic [ADR_W-1:0]  adr2;
        logic [D_size-1:0] data;
        logic [D_size-1:0] datachk;
    } gclop_t;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        SWAP  = 2'd2
    } gclexec_state_t;

    function automatic logic is_read(input gclcmd_t c);
        return (c == RDA) || (c == CPAB);
    endfunction

endpackage

// File: rtl/gcl_exec_m_sram.sv
// Single-port synchronous RAM, 2**A_size x D_size, registered read.
// A write cycle leaves the read register unchanged.
module gcl_sram_m
    import gcltypes::*;
(
    input  logic              clk,
    input  logic              i_we,
    input  logic [A_size-1:0] i_addr,
    input  logic [D_size-1:0] i_wdata,
    output logic [D_size-1:0] o_rdata
);

    logic [D_size-1:0] r_mem [2**A_size];
    logic [D_size-1:0] r_q;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end else begin
            r_q <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_q;

endmodule

// File: rtl/gcl_exec_m.sv
// GC copy execution stage: S1 command register, S2 RAM-A access, response at S2 output.
// Semispace roles swap after a drain; the controller always reads A and writes B.
module gcl_exec_m
    import gcltypes::*;
#(
    parameter int CNT_W = 32,
    parameter int ERR_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  gclop_t            gclop_in,
    output logic              in_ready,
    input  logic              swap_req,
    output logic              swap_done,
    output logic              space_sel,
    output logic              rsp_valid,
    output logic [ID_W-1:0]   rsp_id,
    output logic [D_size-1:0] rsp_data,
    output logic              rsp_err,
    output logic [CNT_W-1:0]  words_copied,
    output logic [ERR_W-1:0]  err_count,
    output logic              busy,
    output logic              ovf,
    output gclexec_state_t    dbg_state
);

    // Handshake: a command is taken at a rising edge where in_ready=1; a non-NOP
    // command offered while in_ready=0 is dropped and latches ovf.

    gclexec_state_t r_state, w_state_nxt;
    logic           w_toggle;
    logic           r_live;
    logic           r_space_sel;
    logic           r_ovf;

    logic              r_s1_vld;
    logic [ID_W-1:0]   r_s1_id;
    gclcmd_t           r_s1_cmd;
    logic [A_size-1:0] r_s1_adr1;
    logic [A_size-1:0] r_s1_adr2;
    logic [D_size-1:0] r_s1_data;
    logic [D_size-1:0] r_s1_chk;

    logic              r_s2_vld;
    logic [ID_W-1:0]   r_s2_id;
    gclcmd_t           r_s2_cmd;
    logic [A_size-1:0] r_s2_adr2;
    logic [D_size-1:0] r_s2_chk;

    logic              r_rsp_vld;
    logic [ID_W-1:0]   r_rsp_id;
    logic [D_size-1:0] r_rsp_data;
    logic              r_rsp_err;
    logic [CNT_W-1:0]  r_words;
    logic [ERR_W-1:0]  r_errs;

    logic              w_a_we, w_b_we;
    logic [A_size-1:0] w_a_addr, w_b_addr;
    logic [D_size-1:0] w_a_wdata, w_a_rdata;
    logic [D_size-1:0] w_q0, w_q1;
    logic              w_chk_en, w_err;
    logic              w_unused;

    assign w_unused = ^{gclop_in.adr1[ADR_W-1:A_size], gclop_in.adr2[ADR_W-1:A_size]};

    assign in_ready = r_live && (r_state == RUN);

    always_comb begin
        w_state_nxt = r_state;
        w_toggle    = 1'b0;
        case (r_state)
            RUN:     if (swap_req) w_state_nxt = DRAIN;
            DRAIN: begin
                if (!r_s1_vld && !r_s2_vld) begin
                    w_state_nxt = SWAP;
                    w_toggle    = 1'b1;
                end
            end
            SWAP:    w_state_nxt = RUN;
            default: w_state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= RUN;
            r_live      <= 1'b0;
            r_space_sel <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_live  <= 1'b1;
            if (w_toggle) r_space_sel <= ~r_space_sel;
            if (gclop_in.cmd != NOP && !in_ready) r_ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1_vld  <= 1'b0;
            r_s1_id   <= '0;
            r_s1_cmd  <= NOP;
            r_s1_adr1 <= '0;
            r_s1_adr2 <= '0;
            r_s1_data <= '0;
            r_s1_chk  <= '0;
            r_s2_vld  <= 1'b0;
            r_s2_id   <= '0;
            r_s2_cmd  <= NOP;
            r_s2_adr2 <= '0;
            r_s2_chk  <= '0;
        end else begin
            if (in_ready) begin
                r_s1_vld  <= (gclop_in.cmd != NOP);
                r_s1_id   <= gclop_in.id;
                r_s1_cmd  <= gclop_in.cmd;
                r_s1_adr1 <= gclop_in.adr1[A_size-1:0];
                r_s1_adr2 <= gclop_in.adr2[A_size-1:0];
                r_s1_data <= gclop_in.data;
                r_s1_chk  <= gclop_in.datachk;
            end else begin
                r_s1_vld <= 1'b0;
            end
            r_s2_vld  <= r_s1_vld;
            r_s2_id   <= r_s1_id;
            r_s2_cmd  <= r_s1_cmd;
            r_s2_adr2 <= r_s1_adr2;
            r_s2_chk  <= r_s1_chk;
        end
    end

    // A port serves S1 (WRA write or read into S2), B port takes the CPAB write from S2.
    assign w_a_we    = r_s1_vld && (r_s1_cmd == WRA);
    assign w_a_addr  = r_s1_adr1;
    assign w_a_wdata = r_s1_data;
    assign w_b_we    = r_s2_vld && (r_s2_cmd == CPAB);
    assign w_b_addr  = r_s2_adr2;
    assign w_a_rdata = r_space_sel ? w_q1 : w_q0;

    gcl_sram_m u_ram0 (
        .clk     (clk),
        .i_we    (r_space_sel ? w_b_we : w_a_we),
        .i_addr  (r_space_sel ? w_b_addr : w_a_addr),
        .i_wdata (r_space_sel ? w_a_rdata : w_a_wdata),
        .o_rdata (w_q0)
    );

    gcl_sram_m u_ram1 (
        .clk     (clk),
        .i_we    (r_space_sel ? w_a_we : w_b_we),
        .i_addr  (r_space_sel ? w_a_addr : w_b_addr),
        .i_wdata (r_space_sel ? w_a_wdata : w_a_rdata),
        .o_rdata (w_q1)
    );

    // A datachk with any X/Z bit disables the compare in simulation only.
`ifdef SYNTHESIS
    assign w_chk_en = 1'b1;
`else
    assign w_chk_en = !$isunknown(r_s2_chk);
`endif

    assign w_err = r_s2_vld && is_read(r_s2_cmd) && w_chk_en && (r_s2_chk != w_a_rdata);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rsp_vld  <= 1'b0;
            r_rsp_id   <= '0;
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b0;
            r_words    <= '0;
            r_errs     <= '0;
        end else begin
            r_rsp_vld  <= r_s2_vld;
            r_rsp_id   <= r_s2_vld ? r_s2_id : '0;
            r_rsp_data <= (r_s2_vld && is_read(r_s2_cmd)) ? w_a_rdata : '0;
            r_rsp_err  <= w_err;
            if (w_b_we) r_words <= r_words + CNT_W'(1);
            if (w_err && (r_errs != '1)) r_errs <= r_errs + ERR_W'(1);
        end
    end

    assign swap_done    = (r_state == SWAP);
    assign space_sel    = r_space_sel;
    assign rsp_valid    = r_rsp_vld;
    assign rsp_id       = r_rsp_id;
    assign rsp_data     = r_rsp_data;
    assign rsp_err      = r_rsp_err;
    assign words_copied = r_words;
    assign err_count    = r_errs;
    assign busy         = r_s1_vld || r_s2_vld || (r_state != RUN);
    assign ovf          = r_ovf;
    assign dbg_state    = r_state;

endmodule

// File: tb/tb_gcl_exec_m.sv
// Bench for gcl_exec_m: directed scenarios plus random traffic checked against
// a transaction-level model of the two semispaces and the response stream.
module tb_gcl_exec_m;
    import gcltypes::*;

    localparam int T_ERR_W = 4;

    logic                 clk = 1'b0;
    logic                 reset_n = 1'b0;
    gclop_t               gclop_in = '0;
    logic                 in_ready;
    logic                 swap_req = 1'b0;
    logic                 swap_done;
    logic                 space_sel;
    logic                 rsp_valid;
    logic [ID_W-1:0]      rsp_id;
    logic [D_size-1:0]    rsp_data;
    logic                 rsp_err;
    logic [31:0]          words_copied;
    logic [T_ERR_W-1:0]   err_count;
    logic                 busy;
    logic                 ovf;
    gclexec_state_t       dbg_state;

    always #5 clk = ~clk;

    gcl_exec_m #(.CNT_W(32), .ERR_W(T_ERR_W)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .gclop_in     (gclop_in),
        .in_ready     (in_ready),
        .swap_req     (swap_req),
        .swap_done    (swap_done),
        .space_sel    (space_sel),
        .rsp_valid    (rsp_valid),
        .rsp_id       (rsp_id),
        .rsp_data     (rsp_data),
        .rsp_err      (rsp_err),
        .words_copied (words_copied),
        .err_count    (err_count),
        .busy         (busy),
        .ovf          (ovf),
        .dbg_state    (dbg_state)
    );

    typedef struct {
        logic [ID_W-1:0]   id;
        logic [D_size-1:0] data;
        logic              err;
        logic              cp;
        logic [A_size-1:0] adr2;
        int                bsel;
        int                due;
    } exp_t;

    exp_t               exp_q[$];
    logic [D_size-1:0]  mem [2][2**A_size];
    int                 checks = 0;
    int                 errors = 0;
    int                 cyc = 0;
    int                 m_sel = 0;
    logic               m_ovf = 1'b0;
    logic [31:0]        m_copied = '0;
    logic [T_ERR_W-1:0] m_err = '0;
    logic [ID_W-1:0]    next_id = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock; afterwards compare the response port and counters with the model.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            e = exp_q.pop_front();
            chk("rsp_valid", rsp_valid, 1);
            chk("rsp_id", rsp_id, e.id);
            chk("rsp_data", rsp_data, e.data);
            chk("rsp_err", rsp_err, e.err);
            if (e.cp) begin
                mem[e.bsel][e.adr2] = e.data;
                m_copied++;
            end
            if (e.err && m_err != '1) m_err++;
        end else begin
            chk("rsp_idle", rsp_valid, 0);
        end
        chk("words_copied", words_copied, m_copied);
        chk("err_count", err_count, m_err);
    endtask

    task automatic send(input gclcmd_t cmd, input logic [ADR_W-1:0] a1, input logic [ADR_W-1:0] a2,
                        input logic [D_size-1:0] data, input logic [D_size-1:0] dchk);
        exp_t e;
        logic [D_size-1:0] d;
        chk("in_ready_send", in_ready, 1);
        gclop_in.id      = next_id;
        gclop_in.cmd     = cmd;
        gclop_in.adr1    = a1;
        gclop_in.adr2    = a2;
        gclop_in.data    = data;
        gclop_in.datachk = dchk;
        if (cmd != NOP) begin
            e.id   = next_id;
            e.due  = cyc + 3;
            e.adr2 = a2[A_size-1:0];
            e.bsel = 1 - m_sel;
            e.cp   = (cmd == CPAB);
            if (cmd == WRA) begin
                mem[m_sel][a1[A_size-1:0]] = data;
                e.data = '0;
                e.err  = 1'b0;
            end else begin
                d = mem[m_sel][a1[A_size-1:0]];
                e.data = d;
                e.err  = !$isunknown(dchk) && (dchk != d);
            end
            exp_q.push_back(e);
            next_id++;
        end
        tick();
        gclop_in = '0;
    endtask

    task automatic flush();
        int n = 0;
        while (exp_q.size() > 0 && n < 10) begin
            tick();
            n++;
        end
        chk("flush_empty", exp_q.size(), 0);
        chk("flush_busy", busy, 0);
    endtask

    task automatic do_swap(input bit inject, input int exp_low);
        int n = 0;
        int nd = 0;
        chk("in_ready_pre_swap", in_ready, 1);
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        while (in_ready === 1'b0 && n < 20) begin
            if (n == 0) chk("state_drain", dbg_state, DRAIN);
            if (swap_done === 1'b1) nd++;
            if (n == 0 && inject) begin
                gclop_in.cmd  = WRA;
                gclop_in.adr1 = 6'd3;
                gclop_in.data = 8'hA5;
                m_ovf = 1'b1;
            end
            tick();
            gclop_in = '0;
            n++;
        end
        m_sel = 1 - m_sel;
        chk("swap_low_cycles", n, exp_low);
        chk("swap_done_count", nd, 1);
        chk("swap_done_clear", swap_done, 0);
        chk("space_sel", space_sel, m_sel);
        chk("ovf", ovf, m_ovf);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        exp_q.delete();
        m_copied = '0;
        m_err = '0;
        m_sel = 0;
        m_ovf = 1'b0;
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_swap_done", swap_done, 0);
        chk("rst_space_sel", space_sel, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_rsp_data", rsp_data, 0);
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        chk("post_rst_in_ready", in_ready, 1);
        chk("post_rst_state", dbg_state, RUN);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [D_size-1:0] dv;
        logic [ADR_W-1:0]  ra1;
        int                c;

        do_reset();

        // Give every word in both semispaces a known value.
        for (int a = 0; a < 2**A_size; a++) send(WRA, ADR_W'(a), '0, D_size'($urandom), '0);
        flush();
        do_swap(1'b0, 2);
        for (int a = 0; a < 2**A_size; a++) send(WRA, ADR_W'(a), '0, D_size'($urandom), '0);
        flush();
        do_swap(1'b0, 2);
        do_reset();

        // Write then read on back-to-back cycles, high address bits set on the read.
        send(WRA, 6'd2, 6'd0, 8'd4, 8'd0);
        send(RDA, 6'h32, 6'd0, 8'd0, 8'd4);
        flush();

        // Copy A[0] -> B[4], then read it back from the new A after a swap.
        send(WRA, 6'd0, 6'd0, 8'd2, 8'd0);
        send(CPAB, 6'd0, 6'd4, 8'd0, 8'd2);
        flush();
        chk("copy_count", words_copied, 1);
        do_swap(1'b0, 2);
        send(RDA, 6'd4, 6'd0, 8'd0, 8'd2);
        flush();

        // Mismatch on a copy.
        send(WRA, 6'd0, 6'd0, 8'd2, 8'd0);
        send(CPAB, 6'd0, 6'd5, 8'd0, 8'd3);
        flush();
        chk("err_count_one", err_count, 1);

        // Unknown datachk must not flag.
        send(RDA, 6'd0, 6'd0, 8'd0, 'x);
        flush();

        // Swap with S1 and S2 both occupied.
        send(WRA, 6'd9, 6'd0, 8'h5C, 8'd0);
        send(RDA, 6'd9, 6'd0, 8'd0, 8'h5C);
        do_swap(1'b0, 3);
        flush();

        // WRA offered during DRAIN is dropped; address 3 must keep its old value.
        do_swap(1'b1, 2);
        do_swap(1'b0, 2);
        send(RDA, 6'd3, 6'd0, 8'd0, mem[m_sel][3]);
        flush();

        // Saturate the error counter.
        for (int i = 0; i < 20; i++) begin
            dv = mem[m_sel][1];
            send(RDA, 6'd1, 6'd0, 8'd0, ~dv);
        end
        flush();
        chk("err_sat", err_count, 4'hF);

        // Reset between the A read and the B write of a copy.
        send(WRA, 6'd1, 6'd0, 8'h77, 8'd0);
        send(CPAB, 6'd1, 6'd7, 8'd0, 8'h77);
        tick();
        do_reset();
        chk("wc_after_reset", words_copied, 0);
        do_swap(1'b0, 2);
        send(RDA, 6'd7, 6'd0, 8'd0, mem[m_sel][7]);
        flush();

        // Random traffic with occasional swaps.
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                flush();
                do_swap(1'b0, 2);
            end else begin
                ra1 = ADR_W'($urandom);
                c = $urandom_range(0, 7);
                if (c < 4) dv = mem[m_sel][ra1[A_size-1:0]];
                else if (c == 4) dv = 'x;
                else dv = D_size'($urandom);
                send(gclcmd_t'($urandom_range(0, 3)), ra1, ADR_W'($urandom), D_size'($urandom), dv);
            end
        end
        flush();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
